// File: rtl/axis_usr_split_buf.sv
// Registered tuser/tdata splitter: forms one output word per accepted beat, tracks a
// tuser flag bit and its rising edges, and buffers through a 2-entry skid pair.
module axis_usr_split_buf #(
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int AXIS_TUSER_WIDTH = 32,
    parameter int DATA_BITS        = 16,
    parameter int USER_BITS        = 16,
    parameter int FLAG_BIT         = 16,
    parameter int CNT_WIDTH        = 32
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic [1:0]                  cfg_mode,
    input  logic                        cnt_clear,
    output logic                        user_data,
    output logic [CNT_WIDTH-1:0]        flag_cnt,
    output logic                        s_axis_tready,
    input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic                        s_axis_tvalid,
    input  logic [AXIS_TUSER_WIDTH-1:0] s_axis_tuser,
    input  logic                        m_axis_tready,
    output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                        m_axis_tvalid
);

    typedef enum logic [1:0] {
        MODE_PACK  = 2'd0,
        MODE_DATA  = 2'd1,
        MODE_USER  = 2'd2,
        MODE_GATED = 2'd3
    } mode_e;

    mode_e                       mode;
    logic                        accept;
    logic                        flag;
    logic                        fwd;
    logic                        out_xfer;
    logic [AXIS_TDATA_WIDTH-1:0] word;

    logic                        out_valid_q, out_valid_d;
    logic [AXIS_TDATA_WIDTH-1:0] out_data_q,  out_data_d;
    logic                        skid_valid_q, skid_valid_d;
    logic [AXIS_TDATA_WIDTH-1:0] skid_data_q,  skid_data_d;
    logic                        s_ready_q,   s_ready_d;
    logic                        user_data_q, user_data_d;
    logic                        prev_flag_q, prev_flag_d;
    logic [CNT_WIDTH-1:0]        flag_cnt_q,  flag_cnt_d;

    always_comb begin
        mode   = mode_e'(cfg_mode);
        flag   = s_axis_tuser[FLAG_BIT];
        accept = s_axis_tvalid & s_ready_q;
        word   = '0;
        case (mode)
            MODE_DATA: word = s_axis_tdata;
            MODE_USER: word[USER_BITS-1:0] = s_axis_tuser[USER_BITS-1:0];
            default: begin
                word[DATA_BITS-1:0]         = s_axis_tdata[DATA_BITS-1:0];
                word[DATA_BITS +: USER_BITS] = s_axis_tuser[USER_BITS-1:0];
            end
        endcase
        // Gated mode still consumes a flag-low beat; it just never reaches the buffer.
        fwd = accept & ((mode != MODE_GATED) | flag);
    end

    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        out_xfer     = out_valid_q & m_axis_tready;

        // With the skid full, s_ready_q is low, so no new beat can arrive alongside the drain.
        if (skid_valid_q) begin
            if (out_xfer) begin
                out_data_d   = skid_data_q;
                skid_valid_d = 1'b0;
            end
        end else if (!out_valid_q || out_xfer) begin
            out_valid_d = fwd;
            if (fwd) begin
                out_data_d = word;
            end
        end else if (fwd) begin
            skid_valid_d = 1'b1;
            skid_data_d  = word;
        end

        s_ready_d = !skid_valid_d;
    end

    always_comb begin
        user_data_d = user_data_q;
        prev_flag_d = prev_flag_q;
        flag_cnt_d  = flag_cnt_q;
        if (accept) begin
            user_data_d = flag;
            prev_flag_d = flag;
        end
        if (cnt_clear) begin
            flag_cnt_d = '0;
        end else if (accept && flag && !prev_flag_q) begin
            flag_cnt_d = flag_cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            s_ready_q    <= 1'b0;
            user_data_q  <= 1'b0;
            prev_flag_q  <= 1'b0;
            flag_cnt_q   <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            s_ready_q    <= s_ready_d;
            user_data_q  <= user_data_d;
            prev_flag_q  <= prev_flag_d;
            flag_cnt_q   <= flag_cnt_d;
        end
    end

    assign m_axis_tvalid = out_valid_q;
    assign m_axis_tdata  = out_data_q;
    assign s_axis_tready = s_ready_q;
    assign user_data     = user_data_q;
    assign flag_cnt      = flag_cnt_q;

endmodule

// File: tb/tb_axis_usr_split_buf.sv
// Scoreboard bench for axis_usr_split_buf: a default instance plus a 4-bit counter
// instance sharing the same stimulus.
module tb_axis_usr_split_buf;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic [1:0]  cfg_mode;
    logic        cnt_clear;
    logic [31:0] s_tdata, s_tuser;
    logic        s_tvalid, m_tready;

    logic        user_data, s_tready, m_tvalid;
    logic [31:0] flag_cnt, m_tdata;
    logic        user_data4, s_tready4, m_tvalid4;
    logic [3:0]  flag_cnt4;
    logic [31:0] m_tdata4;

    always #5 aclk = ~aclk;

    axis_usr_split_buf dut (
        .aclk(aclk), .aresetn(aresetn), .cfg_mode(cfg_mode), .cnt_clear(cnt_clear),
        .user_data(user_data), .flag_cnt(flag_cnt), .s_axis_tready(s_tready),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tuser(s_tuser),
        .m_axis_tready(m_tready), .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid)
    );

    axis_usr_split_buf #(.CNT_WIDTH(4)) dut4 (
        .aclk(aclk), .aresetn(aresetn), .cfg_mode(cfg_mode), .cnt_clear(cnt_clear),
        .user_data(user_data4), .flag_cnt(flag_cnt4), .s_axis_tready(s_tready4),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tuser(s_tuser),
        .m_axis_tready(m_tready), .m_axis_tdata(m_tdata4), .m_axis_tvalid(m_tvalid4)
    );

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    int unsigned n_out = 0;

    logic [31:0] q[$];
    logic [31:0] mcnt;
    logic        mprev, muser, msready;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] form(input logic [1:0] mode, input logic [31:0] d,
                                         input logic [31:0] u);
        case (mode)
            2'd1:    return d;
            2'd2:    return {16'h0000, u[15:0]};
            default: return {u[15:0], d[15:0]};
        endcase
    endfunction

    task automatic cyc(input logic v, input logic [31:0] d, input logic [31:0] u,
                       input logic mr, input logic clr, input logic [1:0] mode,
                       output logic acc);
        @(negedge aclk);
        s_tvalid  = v;
        s_tdata   = d;
        s_tuser   = u;
        m_tready  = mr;
        cnt_clear = clr;
        cfg_mode  = mode;
        acc = v && msready;
        if (q.size() > 0 && mr) begin
            void'(q.pop_front());
            n_out++;
        end
        if (acc) begin
            if (mode != 2'd3 || u[16]) q.push_back(form(mode, d, u));
            muser = u[16];
        end
        if (clr) mcnt = '0;
        else if (acc && u[16] && !mprev) mcnt = mcnt + 32'd1;
        if (acc) mprev = u[16];
        @(posedge aclk);
        #1;
        msready = (q.size() < 2);
        chk("m_tvalid", {31'b0, m_tvalid}, {31'b0, q.size() > 0});
        if (q.size() > 0) chk("m_tdata", m_tdata, q[0]);
        chk("s_tready", {31'b0, s_tready}, {31'b0, msready});
        chk("user_data", {31'b0, user_data}, {31'b0, muser});
        chk("flag_cnt", flag_cnt, mcnt);
        chk("flag_cnt4", {28'b0, flag_cnt4}, {28'b0, mcnt[3:0]});
    endtask

    task automatic idle(input int unsigned n, input logic mr);
        logic acc;
        for (int unsigned i = 0; i < n; i++) cyc(1'b0, '0, '0, mr, 1'b0, 2'd0, acc);
    endtask

    task automatic do_reset();
        @(negedge aclk);
        #2;
        s_tvalid = 1'b0;
        aresetn  = 1'b0;
        #1;
        chk("rst m_tvalid", {31'b0, m_tvalid}, 32'd0);
        chk("rst m_tdata", m_tdata, 32'd0);
        chk("rst s_tready", {31'b0, s_tready}, 32'd0);
        chk("rst flag_cnt", flag_cnt, 32'd0);
        chk("rst user_data", {31'b0, user_data}, 32'd0);
        q.delete();
        mcnt    = '0;
        mprev   = 1'b0;
        muser   = 1'b0;
        msready = 1'b0;
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        aresetn = 1'b1;
    endtask

    // Send n beats, holding each until accepted, with m_tready following a repeating pattern.
    task automatic stream(input logic [31:0] d[$], input logic [31:0] u[$], input logic [1:0] mode,
                          input logic [3:0] rdy_pat, input string tag);
        int unsigned idx = 0;
        int unsigned c = 0;
        logic acc;
        while ((idx < d.size() || q.size() > 0) && c < 200) begin
            if (idx < d.size()) cyc(1'b1, d[idx], u[idx], rdy_pat[c % 4], 1'b0, mode, acc);
            else cyc(1'b0, '0, '0, rdy_pat[c % 4], 1'b0, mode, acc);
            if (acc) idx++;
            c++;
        end
        chk({tag, " drained"}, {31'b0, (idx == d.size()) && (q.size() == 0)}, 32'd1);
    endtask

    initial begin
        logic        acc;
        logic [31:0] dq[$];
        logic [31:0] uq[$];
        int unsigned base;

        aresetn = 1'b0; cfg_mode = 2'd0; cnt_clear = 1'b0;
        s_tdata = '0; s_tuser = '0; s_tvalid = 1'b0; m_tready = 1'b0;
        do_reset();
        idle(1, 1'b1);

        // Single pack beat: 1-cycle latency and flag edge counted.
        cyc(1'b1, 32'h0000ABCD, 32'h00011234, 1'b1, 1'b0, 2'd0, acc);
        chk("pack word", m_tdata, 32'h1234ABCD);
        chk("pack valid", {31'b0, m_tvalid}, 32'd1);
        chk("pack flag_cnt", flag_cnt, 32'd1);
        idle(2, 1'b1);

        // 8-beat stream under backpressure 1,0,0,1.
        dq.delete(); uq.delete();
        for (int unsigned i = 0; i < 8; i++) begin
            dq.push_back(32'h1000 + i * 32'h111);
            uq.push_back($urandom);
        end
        base = n_out;
        stream(dq, uq, 2'd0, 4'b1001, "stream8");
        chk("stream8 count", n_out - base, 32'd8);

        // Gated pack with flag pattern 1,0,0,1,1,0,1.
        do_reset();
        idle(1, 1'b1);
        dq.delete(); uq.delete();
        for (int unsigned i = 0; i < 7; i++) begin
            dq.push_back(32'hA000 + i);
            uq.push_back({15'h0, 1'b0, 16'h5000 + 16'(i)});
        end
        uq[0][16] = 1'b1; uq[3][16] = 1'b1; uq[4][16] = 1'b1; uq[6][16] = 1'b1;
        base = n_out;
        stream(dq, uq, 2'd3, 4'b1111, "gated");
        chk("gated count", n_out - base, 32'd4);
        chk("gated flag_cnt", flag_cnt, 32'd3);
        chk("gated user_data", {31'b0, user_data}, 32'd1);

        // Data pass and user-only.
        cyc(1'b1, 32'hDEADBEEF, 32'h0000CAFE, 1'b1, 1'b0, 2'd1, acc);
        chk("mode1 word", m_tdata, 32'hDEADBEEF);
        cyc(1'b1, 32'hDEADBEEF, 32'h0000CAFE, 1'b1, 1'b0, 2'd2, acc);
        chk("mode2 word", m_tdata, 32'h0000CAFE);
        idle(1, 1'b1);

        // Counter wrap on the 4-bit instance, then clear coinciding with a rising edge.
        cyc(1'b0, '0, '0, 1'b1, 1'b1, 2'd0, acc);
        for (int unsigned i = 0; i < 32; i++)
            cyc(1'b1, 32'(i), {15'h0, (i % 2 == 0), 16'h0}, 1'b1, 1'b0, 2'd1, acc);
        chk("wrap cnt32", flag_cnt, 32'd16);
        chk("wrap cnt4", {28'b0, flag_cnt4}, 32'd0);
        cyc(1'b1, 32'h77, 32'h00010000, 1'b1, 1'b1, 2'd1, acc);
        chk("clear cnt32", flag_cnt, 32'd0);
        chk("clear cnt4", {28'b0, flag_cnt4}, 32'd0);
        cyc(1'b1, 32'h78, 32'h00010000, 1'b1, 1'b0, 2'd1, acc);
        chk("clear prev kept", flag_cnt, 32'd0);
        idle(1, 1'b1);

        // Reset with two beats buffered and the master stalled.
        for (int unsigned i = 0; i < 3; i++)
            cyc(1'b1, 32'hB0 + i, 32'h0, 1'b0, 1'b0, 2'd1, acc);
        chk("full s_tready", {31'b0, s_tready}, 32'd0);
        do_reset();
        idle(2, 1'b0);
        cyc(1'b1, 32'hC0FFEE00, 32'h0, 1'b1, 1'b0, 2'd1, acc);
        chk("post-rst word", m_tdata, 32'hC0FFEE00);
        idle(2, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
